// File: rtl/rgb_pwm_fader_pkg.sv
// Shared defaults, duty type and fade step helper for the RGB PWM fader.
package rgb_pwm_pkg;

  localparam int DEF_CHANNELS     = 3;
  localparam int DEF_DUTY_W       = 8;
  localparam int DEF_PRESCALE     = 390;
  localparam int DEF_FADE_PERIODS = 4;

  typedef logic [DEF_DUTY_W-1:0] duty_t;

  // One linear fade step; never overshoots the target.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    if (cur < tgt)
      return cur + 1'b1;
    else if (cur > tgt)
      return cur - 1'b1;
    return cur;
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_pwm_channel.sv
// One PWM channel: applied duty register, compare, and optional fade step (RGB_PWM_FADE_EN).
// Pin is registered, 1 cycle after compare; always accepts a new target, no backpressure.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              apply,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic [DUTY_W-1:0] tgt,
  output logic [DUTY_W-1:0] cur_duty,
  output logic              led
);

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_duty <= '0;
      led      <= 1'b0;
    end else begin
      led <= enable && (pwm_cnt < cur_duty);
      if (apply) begin
`ifdef RGB_PWM_FADE_EN
        // Fade stepping goes through the package helper, so DUTY_W must not exceed its width.
        cur_duty <= DUTY_W'(step_toward(duty_t'(cur_duty), duty_t'(tgt)));
`else
        cur_duty <= tgt;
`endif
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Multi-channel PWM LED driver; outputs registered 1 cycle after compare, always ready (no backpressure).
// Duties apply on period boundaries; RGB_PWM_FADE_EN adds a linear fade toward each target.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int DUTY_W       = DEF_DUTY_W,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int FADE_PERIODS = DEF_FADE_PERIODS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable_i,
  input  logic [CHANNELS*DUTY_W-1:0] duty_i,
  input  logic                       duty_valid_i,
  output logic [CHANNELS-1:0]        led_o,
  output logic                       period_o,
  output logic                       busy_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // An out-of-range configuration never loads a duty, leaving all pins dark.
  localparam bit CFG_OK = (PRESCALE >= 1) && (FADE_PERIODS >= 1);

  logic [PW-1:0]     presc_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              tick;
  logic              boundary;
  logic              apply;
  logic [DUTY_W-1:0] tgt      [CHANNELS];
  logic [DUTY_W-1:0] cur_duty [CHANNELS];
  logic [CHANNELS-1:0] differs;

  assign tick     = enable_i && (presc_cnt == PW'(PRESCALE - 1));
  assign boundary = tick && (pwm_cnt == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      period_o  <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      if (!enable_i) begin
        presc_cnt <= '0;
        pwm_cnt   <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
        pwm_cnt   <= pwm_cnt + 1'b1;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
      period_o <= boundary;
      busy_o   <= |differs;
    end
  end

  // Targets capture regardless of enable; the last write before a boundary wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) tgt[c] <= '0;
    end else if (duty_valid_i) begin
      for (int c = 0; c < CHANNELS; c++) tgt[c] <= duty_i[c*DUTY_W +: DUTY_W];
    end
  end

`ifdef RGB_PWM_FADE_EN
  localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  logic [FW-1:0] fade_cnt;
  logic          fade_wrap;

  assign fade_wrap = (fade_cnt == FW'(FADE_PERIODS - 1));
  assign apply     = CFG_OK && boundary && fade_wrap;

  always_ff @(posedge clock) begin
    if (reset)
      fade_cnt <= '0;
    else if (boundary)
      fade_cnt <= fade_wrap ? '0 : fade_cnt + 1'b1;
  end
`else
  assign apply = CFG_OK && boundary;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_channel #(
      .DUTY_W(DUTY_W)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .enable  (enable_i),
      .apply   (apply),
      .pwm_cnt (pwm_cnt),
      .tgt     (tgt[c]),
      .cur_duty(cur_duty[c]),
      .led     (led_o[c])
    );
    assign differs[c] = (cur_duty[c] != tgt[c]);
  end

endmodule
